// File: rtl/calc1_port_checker_if.sv
// Bundle of the tapped calc1 port signals and the checker's verdict outputs.
// The slave side is the checker; the master side is whatever drives the taps.
interface calc1_port_checker_if;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp_in;
    logic [0:31] out_data_in;
    logic        pass_pulse;
    logic        fail_pulse;
    logic [0:1]  fail_code;
    logic        busy;
    logic [0:15] pass_count;
    logic [0:15] fail_count;

    modport master (
        output req_cmd_in, req_data_in, out_resp_in, out_data_in,
        input  pass_pulse, fail_pulse, fail_code, busy, pass_count, fail_count
    );

    modport slave (
        input  req_cmd_in, req_data_in, out_resp_in, out_data_in,
        output pass_pulse, fail_pulse, fail_code, busy, pass_count, fail_count
    );
endinterface

// File: rtl/calc1_port_checker.sv
// Passive checker for one calc1 port: it predicts each request's result and
// grades the DUV response, flagging timeouts and responses nobody asked for.
module calc1_port_checker #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 c_clk,
    input  logic                 reset,
    calc1_port_checker_if.slave  mon
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP2,
        S_WAIT
    } state_e;

    state_e      state_q,    state_d;
    logic [3:0]  cmd_q,      cmd_d;
    logic [31:0] op1_q,      op1_d;
    logic [1:0]  expResp_q,  expResp_d;
    logic [31:0] expData_q,  expData_d;
    logic [7:0]  waitCnt_q,  waitCnt_d;
    logic        pass_q,     pass_d;
    logic        fail_q,     fail_d;
    logic [1:0]  failCode_q, failCode_d;
    logic        busy_q,     busy_d;
    logic [15:0] passCnt_q,  passCnt_d;
    logic [15:0] failCnt_q,  failCnt_d;

    logic [1:0]  calcResp;
    logic [31:0] calcData;
    logic [32:0] sum33;
    logic [4:0]  shamt;

    // Operand2 is only on the bus during OP2, so the prediction is formed
    // straight from the live data and only the verdict-relevant result is kept.
    always_comb begin
        sum33    = {1'b0, op1_q} + {1'b0, mon.req_data_in};
        shamt    = mon.req_data_in[27:31];
        calcResp = 2'd2;
        calcData = 32'd0;
        case (cmd_q)
            4'd1: begin
                if (!sum33[32]) begin
                    calcResp = 2'd1;
                    calcData = sum33[31:0];
                end
            end
            4'd2: begin
                if (op1_q >= mon.req_data_in) begin
                    calcResp = 2'd1;
                    calcData = op1_q - mon.req_data_in;
                end
            end
            4'd5: begin
                calcResp = 2'd1;
                calcData = op1_q << shamt;
            end
            4'd6: begin
                calcResp = 2'd1;
                calcData = op1_q >> shamt;
            end
            default: begin
                calcResp = 2'd2;
                calcData = 32'd0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        op1_d      = op1_q;
        expResp_d  = expResp_q;
        expData_d  = expData_q;
        waitCnt_d  = waitCnt_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        failCode_d = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (mon.out_resp_in != 2'd0) begin
                    fail_d     = 1'b1;
                    failCode_d = 2'd3;
                end
                if (mon.req_cmd_in != 4'd0) begin
                    cmd_d   = mon.req_cmd_in;
                    op1_d   = mon.req_data_in;
                    state_d = S_OP2;
                end
            end
            S_OP2: begin
                expResp_d = calcResp;
                expData_d = calcData;
                waitCnt_d = 8'd0;
                state_d   = S_WAIT;
                if (mon.out_resp_in != 2'd0) begin
                    fail_d     = 1'b1;
                    failCode_d = 2'd3;
                end
            end
            S_WAIT: begin
                // A response always wins over a timeout landing on the same cycle.
                if (mon.out_resp_in != 2'd0) begin
                    state_d = S_IDLE;
                    if (mon.out_resp_in != expResp_q) begin
                        fail_d     = 1'b1;
                        failCode_d = 2'd0;
                    end else if (expResp_q == 2'd1 && mon.out_data_in != expData_q) begin
                        fail_d     = 1'b1;
                        failCode_d = 2'd1;
                    end else begin
                        pass_d = 1'b1;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                    if (waitCnt_d == TIMEOUT_C) begin
                        fail_d     = 1'b1;
                        failCode_d = 2'd2;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        passCnt_d = passCnt_q;
        failCnt_d = failCnt_q;
        if (pass_d && passCnt_q != 16'hFFFF) begin
            passCnt_d = passCnt_q + 16'd1;
        end
        if (fail_d && failCnt_q != 16'hFFFF) begin
            failCnt_d = failCnt_q + 16'd1;
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= 4'd0;
            op1_q      <= 32'd0;
            expResp_q  <= 2'd0;
            expData_q  <= 32'd0;
            waitCnt_q  <= 8'd0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            failCode_q <= 2'd0;
            busy_q     <= 1'b0;
            passCnt_q  <= 16'd0;
            failCnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            op1_q      <= op1_d;
            expResp_q  <= expResp_d;
            expData_q  <= expData_d;
            waitCnt_q  <= waitCnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            failCode_q <= failCode_d;
            busy_q     <= busy_d;
            passCnt_q  <= passCnt_d;
            failCnt_q  <= failCnt_d;
        end
    end

    assign mon.pass_pulse = pass_q;
    assign mon.fail_pulse = fail_q;
    assign mon.fail_code  = failCode_q;
    assign mon.busy       = busy_q;
    assign mon.pass_count = passCnt_q;
    assign mon.fail_count = failCnt_q;

endmodule

// File: tb/tb_calc1_port_checker.sv
// Directed bench for calc1_port_checker with a transaction-level reference
// model compared every cycle, plus literal expectations for key scenarios.
module tb_calc1_port_checker;

    localparam int unsigned TIMEOUT = 16;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    calc1_port_checker_if bus();

    calc1_port_checker #(.TIMEOUT(TIMEOUT)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .mon   (bus)
    );

    always #5 c_clk = ~c_clk;

    // Reference model state: one outstanding request at most.
    bit          mBusy = 0;
    bit          mNeedOp2 = 0;
    int          mWaits = 0;
    logic [3:0]  mCmd = '0;
    logic [31:0] mOp1 = '0;
    logic [1:0]  mExpResp = '0;
    logic [31:0] mExpData = '0;
    bit          ePass = 0;
    bit          eFail = 0;
    logic [1:0]  eCode = '0;
    int          ePassCnt = 0;
    int          eFailCnt = 0;

    function automatic void expectFor(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b, output logic [1:0] r,
                                      output logic [31:0] d);
        logic [63:0] wide;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                wide = {32'd0, a} + {32'd0, b};
                if (wide <= 64'hFFFF_FFFF) begin
                    r = 2'd1;
                    d = wide[31:0];
                end
            end
            4'd2: if (!(a < b)) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << b[4:0]; end
            4'd6: begin r = 2'd1; d = a >> b[4:0]; end
            default: r = 2'd2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model advances on the same edge that the checker samples.
    always @(posedge c_clk or posedge reset) begin
        if (reset) begin
            mBusy = 0; mNeedOp2 = 0; mWaits = 0; mCmd = '0; mOp1 = '0;
            mExpResp = '0; mExpData = '0; ePass = 0; eFail = 0; eCode = '0;
            ePassCnt = 0; eFailCnt = 0;
        end else begin
            ePass = 0; eFail = 0; eCode = 2'd0;
            if (!mBusy) begin
                if (bus.out_resp_in != 2'd0) begin eFail = 1; eCode = 2'd3; end
                if (bus.req_cmd_in != 4'd0) begin
                    mBusy = 1; mNeedOp2 = 1;
                    mCmd = bus.req_cmd_in; mOp1 = bus.req_data_in;
                end
            end else if (mNeedOp2) begin
                expectFor(mCmd, mOp1, bus.req_data_in, mExpResp, mExpData);
                mNeedOp2 = 0; mWaits = 0;
                if (bus.out_resp_in != 2'd0) begin eFail = 1; eCode = 2'd3; end
            end else if (bus.out_resp_in != 2'd0) begin
                mBusy = 0;
                if (bus.out_resp_in != mExpResp) begin eFail = 1; eCode = 2'd0; end
                else if (mExpResp == 2'd1 && bus.out_data_in != mExpData) begin eFail = 1; eCode = 2'd1; end
                else ePass = 1;
            end else begin
                mWaits++;
                if (mWaits == TIMEOUT) begin eFail = 1; eCode = 2'd2; mBusy = 0; end
            end
            if (ePass && ePassCnt < 65535) ePassCnt++;
            if (eFail && eFailCnt < 65535) eFailCnt++;
        end
    end

    always @(negedge c_clk) begin
        checkOutput("model_pass_pulse", 32'(bus.pass_pulse), 32'(ePass));
        checkOutput("model_fail_pulse", 32'(bus.fail_pulse), 32'(eFail));
        if (eFail) checkOutput("model_fail_code", 32'(bus.fail_code), 32'(eCode));
        checkOutput("model_busy", 32'(bus.busy), 32'(mBusy));
        checkOutput("model_pass_count", 32'(bus.pass_count), ePassCnt);
        checkOutput("model_fail_count", 32'(bus.fail_count), eFailCnt);
    end

    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] data,
                                 input logic [1:0] resp, input logic [31:0] rdata);
        @(negedge c_clk);
        bus.req_cmd_in  = cmd;
        bus.req_data_in = data;
        bus.out_resp_in = resp;
        bus.out_data_in = rdata;
    endtask

    task automatic sendReq(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        applyStimulus(cmd, op1, 2'd0, 32'd0);
        applyStimulus(4'd0, op2, 2'd0, 32'd0);
    endtask

    // Leaves time at the negedge where the verdict pulse is visible.
    task automatic respond(input int delay, input logic [1:0] code, input logic [31:0] data);
        repeat (delay) applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        applyStimulus(4'd0, 32'd0, code, data);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
    endtask

    task automatic checkVerdict(input string name, input bit expPass, input logic [1:0] code);
        checkOutput({name, "_pass"}, 32'(bus.pass_pulse), 32'(expPass));
        checkOutput({name, "_fail"}, 32'(bus.fail_pulse), 32'(!expPass));
        if (!expPass) checkOutput({name, "_code"}, 32'(bus.fail_code), 32'(code));
    endtask

    initial begin
        bus.req_cmd_in = '0; bus.req_data_in = '0; bus.out_resp_in = '0; bus.out_data_in = '0;
        reset = 1'b1;
        repeat (2) @(negedge c_clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_pass_count", 32'(bus.pass_count), 32'd0);
        checkOutput("reset_fail_count", 32'(bus.fail_count), 32'd0);
        reset = 1'b0;

        // Pin the model with a few hand-derived results.
        begin
            logic [1:0] r; logic [31:0] d;
            expectFor(4'd1, 32'hFFFF_0000, 32'h0000_FFFF, r, d);
            checkOutput("pin_add_data", d, 32'hFFFF_FFFF);
            expectFor(4'd2, 32'd0, 32'd1, r, d);
            checkOutput("pin_sub_resp", 32'(r), 32'd2);
            expectFor(4'd6, 32'h8000_0000, 32'd31, r, d);
            checkOutput("pin_rsh_data", d, 32'h0000_0001);
        end

        sendReq(4'd1, 32'hFFFF_0000, 32'h0000_FFFF);
        respond(3, 2'd1, 32'hFFFF_FFFF);
        checkVerdict("add_ok", 1'b1, 2'd0);
        checkOutput("add_ok_pass_count", 32'(bus.pass_count), 32'd1);

        sendReq(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        respond(0, 2'd1, 32'h0000_0000);
        checkVerdict("add_carry", 1'b0, 2'd0);
        checkOutput("add_carry_fail_count", 32'(bus.fail_count), 32'd1);

        sendReq(4'd5, 32'h0F0F_0F0F, 32'd4);
        respond(1, 2'd1, 32'hF0F0_F0F0);
        checkVerdict("lsh_ok", 1'b1, 2'd0);
        sendReq(4'd5, 32'h0F0F_0F0F, 32'd4);
        respond(1, 2'd1, 32'hF0F0_F0F1);
        checkVerdict("lsh_bad", 1'b0, 2'd1);

        sendReq(4'd2, 32'h0000_0000, 32'h0000_0001);
        repeat (TIMEOUT) applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        checkOutput("tmo_early_fail", 32'(bus.fail_pulse), 32'd0);
        checkOutput("tmo_early_busy", 32'(bus.busy), 32'd1);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        checkVerdict("timeout", 1'b0, 2'd2);
        checkOutput("tmo_busy_drop", 32'(bus.busy), 32'd0);

        applyStimulus(4'd0, 32'd0, 2'd1, 32'd0);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        checkVerdict("spurious_idle", 1'b0, 2'd3);
        checkOutput("spurious_idle_busy", 32'(bus.busy), 32'd0);
        sendReq(4'd1, 32'd1, 32'd1);
        respond(0, 2'd1, 32'd2);
        checkVerdict("add_small", 1'b1, 2'd0);

        // Response on the very cycle the timeout would expire.
        sendReq(4'd1, 32'd2, 32'd3);
        respond(TIMEOUT - 1, 2'd1, 32'd5);
        checkVerdict("resp_beats_tmo", 1'b1, 2'd0);

        sendReq(4'd3, 32'h1234, 32'h5678);
        respond(2, 2'd2, 32'hDEAD_BEEF);
        checkVerdict("cmd3_nodata", 1'b1, 2'd0);

        applyStimulus(4'd1, 32'd5, 2'd1, 32'd0);
        applyStimulus(4'd0, 32'd7, 2'd0, 32'd0);
        checkVerdict("cmd_and_spurious", 1'b0, 2'd3);
        checkOutput("cmd_and_spurious_busy", 32'(bus.busy), 32'd1);
        respond(0, 2'd1, 32'd12);
        checkVerdict("after_capture", 1'b1, 2'd0);

        applyStimulus(4'd2, 32'd10, 2'd0, 32'd0);
        applyStimulus(4'd0, 32'd3, 2'd1, 32'd0);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        checkVerdict("spurious_op2", 1'b0, 2'd3);
        checkOutput("spurious_op2_busy", 32'(bus.busy), 32'd1);
        respond(0, 2'd1, 32'd7);
        checkVerdict("sub_ok", 1'b1, 2'd0);

        sendReq(4'd6, 32'h8000_0000, 32'd31);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        #2 reset = 1'b1;
        @(negedge c_clk);
        checkOutput("rst_mid_pass", 32'(bus.pass_pulse), 32'd0);
        checkOutput("rst_mid_fail", 32'(bus.fail_pulse), 32'd0);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_pass_count", 32'(bus.pass_count), 32'd0);
        checkOutput("rst_mid_fail_count", 32'(bus.fail_count), 32'd0);
        bus.req_cmd_in  = 4'd6;
        bus.req_data_in = 32'h8000_0000;
        reset = 1'b0;
        applyStimulus(4'd0, 32'd31, 2'd0, 32'd0);
        respond(0, 2'd1, 32'h0000_0001);
        checkVerdict("rsh_after_rst", 1'b1, 2'd0);
        checkOutput("rsh_after_rst_count", 32'(bus.pass_count), 32'd1);

        repeat (3) applyStimulus(4'd0, 32'd0, 2'd0, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc1_port_checker.md
CALC1_PORT_CHECKER -- requirements
Module: calc1_port_checker

Interface
Parameters:
REQ-001 The parameter list SHALL be: TIMEOUT, 16, maximum WAIT cycles without a response before a timeout failure (legal range 1..255).
Ports:
REQ-002 c_clk  input  1  single design clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_cmd_in  input  [0:3]  one port's calc1 request command, tapped in parallel with the DUV input.
REQ-005 req_data_in  input  [0:31]  one port's calc1 request data; bit 0 is the MSB.
REQ-006 out_resp_in  input  [0:1]  DUV response code: 0 none, 1 success, 2 overflow/underflow/invalid, 3 unused.
REQ-007 out_data_in  input  [0:31]  DUV result data, sampled when out_resp_in is non-zero.
REQ-008 pass_pulse  output  1  one-cycle strobe for a correct transaction.
REQ-009 fail_pulse  output  1  one-cycle strobe for a failed transaction or protocol error.
REQ-010 fail_code  output  [0:1]  failure cause, valid while fail_pulse is high: 0 response mismatch, 1 data mismatch, 2 timeout, 3 spurious response.
REQ-011 busy  output  1  high in OP2 and WAIT.
REQ-012 pass_count, fail_count  output  [0:15]  saturating event counters.

Function
REQ-013 The FSM SHALL have three states, IDLE, OP2 and WAIT, and all outputs SHALL be registered.
REQ-014 IDLE: when req_cmd_in != 0, the block SHALL latch cmd and operand1 and go to OP2 on the next cycle.
REQ-015 OP2: the block SHALL latch req_data_in as operand2 unconditionally, compute the expected response and data, clear the wait counter, and go to WAIT.
REQ-016 Expected results SHALL be:
  - cmd 1 (add): 33-bit op1+op2; carry out gives resp 2, otherwise resp 1 with the 32-bit sum.
  - cmd 2 (sub): op1<op2 (unsigned) gives resp 2, otherwise resp 1 with op1-op2.
  - cmd 5 (lsh): resp 1, op1 shifted left by op2[27:31], zero fill.
  - cmd 6 (rsh): resp 1, op1 shifted right by op2[27:31], zero fill.
  - cmd 3, 4, 7-15: resp 2.
REQ-017 When the expected response is 2, the block SHALL NOT compare data.
REQ-018 WAIT with out_resp_in != 0: a response code mismatch SHALL give fail code 0; a match of 1 with a data mismatch SHALL give code 1; otherwise the transaction passes. The next state SHALL be IDLE.
REQ-019 WAIT with out_resp_in == 0: the wait counter SHALL increment; on the TIMEOUT-th such cycle the block SHALL give fail code 2 and go to IDLE.
REQ-020 If a response arrives in the same cycle the timeout would fire, the response SHALL take priority.
REQ-021 A non-zero out_resp_in in IDLE or OP2 SHALL give fail code 3 without changing state.
REQ-022 When the command in IDLE is non-zero and a spurious response is present in the same cycle, both the capture and the fail SHALL occur.
REQ-023 req_cmd_in != 0 during WAIT SHALL be ignored; the DUV allows one outstanding request per port.
REQ-024 pass_pulse or fail_pulse SHALL be high for exactly the one cycle after the edge that samples the deciding event.
REQ-025 The two pulses SHALL never be high together.
REQ-026 The appropriate counter SHALL increment with each pulse and hold at 0xFFFF.
REQ-027 Latency from request to pulse SHALL be 2 cycles plus the DUV response delay.

Reset
REQ-028 While reset is high: state SHALL be IDLE, all outputs 0, and latched operands, expected values and wait counter cleared.
REQ-029 Reset asserted in OP2 or WAIT SHALL abandon the transaction with no pulse.
REQ-030 On the first edge after reset release, a command in IDLE SHALL be captured normally.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - add 0xFFFF0000 + 0x0000FFFF, DUV resp 1 / 0xFFFFFFFF after 3 cycles -> one pass_pulse; pass_count=1.
  - add 0xFFFFFFFF + 0x00000001, DUV resp 1 / 0x00000000 -> fail_pulse, fail_code 0; fail_count=1.
  - lsh 0x0F0F0F0F by 4: DUV resp 1 / 0xF0F0F0F0 -> pass; DUV resp 1 / 0xF0F0F0F1 -> fail_code 1.
  - sub 0x00000000 - 0x00000001 with no DUV response -> fail_code 2 on the 16th WAIT cycle; busy then drops.
  - out_resp_in=1 while IDLE -> fail_code 3; state stays IDLE; next add 0x1 + 0x1 with resp 1 / 0x2 -> pass.
  - reset pulsed mid-WAIT of rsh 0x80000000 by 31 -> no pulse, counters 0; after release the same request with resp 1 / 0x00000001 -> pass.
